// File: rtl/jt9346_master.sv
// jt9346_master: Microwire master for 93C46/93C06-class EEPROMs in 16-bit organisation.
// Define JT9346_MASTER_POLL_EN to poll eep_sdo for ready after write-type commands.
module jt9346_master #(
  parameter int AW      = 6,
  parameter int DW      = 16,
  parameter int CLKDIV  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          eep_scs,
  output logic          eep_sclk,
  output logic          eep_sdi,
  input  logic          eep_sdo
);
  localparam int N    = AW + 4;
  localparam int SW   = (N > DW) ? N : DW;
  localparam int HALF = CLKDIV / 2;
  localparam int DIVW = $clog2(2 * CLKDIV);
  localparam int PW   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] CMD_READ  = 3'd0, CMD_WRITE = 3'd1, CMD_ERASE = 3'd2, CMD_EWEN = 3'd3;
  localparam logic [2:0] CMD_EWDS  = 3'd4, CMD_ERAL  = 3'd5, CMD_WRAL  = 3'd6, CMD_RSVD = 3'd7;

  typedef enum logic [2:0] {IDLE, HDR, RDATA, WDATA, CSLOW, POLL, FIN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic [4:0]      bcnt_q, bcnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            scs_q, scs_d, sclk_q, sclk_d, sdi_q, sdi_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [1:0]      op;
  logic [AW-1:0]   afld;
  logic [SW-1:0]   hdr_sh, wd_sh;
  logic            period_end, write_type;

  // Header is {dummy 0, start 1, opcode, address field}, left-aligned in the shifter.
  always_comb begin
    op   = 2'b00;
    afld = addr;
    case (cmd)
      CMD_READ:  op = 2'b10;
      CMD_WRITE: op = 2'b01;
      CMD_ERASE: op = 2'b11;
      CMD_EWEN:  begin afld = '0; afld[AW-1 -: 2] = 2'b11; end
      CMD_EWDS:  afld = '0;
      CMD_ERAL:  begin afld = '0; afld[AW-1 -: 2] = 2'b10; end
      CMD_WRAL:  begin afld = '0; afld[AW-1 -: 2] = 2'b01; end
      default:   ;
    endcase
    hdr_sh = '0;
    hdr_sh[SW-1 -: N] = {2'b01, op, afld};
    wd_sh = '0;
    wd_sh[SW-1 -: DW] = wd_q;
  end

  assign period_end = (div_q == DIVW'(CLKDIV - 1));
  assign write_type = (cmd_q == CMD_WRITE) || (cmd_q == CMD_ERASE) ||
                      (cmd_q == CMD_ERAL)  || (cmd_q == CMD_WRAL);

  always_comb begin
    state_d = state_q;  cmd_d  = cmd_q;  wd_d   = wd_q;   sh_d    = sh_q;
    bcnt_d  = bcnt_q;   div_d  = div_q;  pcnt_d = pcnt_q; busy_d  = busy_q;
    done_d  = 1'b0;     err_d  = err_q;  scs_d  = scs_q;  sclk_d  = sclk_q;
    sdi_d   = sdi_q;    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          busy_d = 1'b1;
          cmd_d  = cmd;
          wd_d   = wdata;
          err_d  = 1'b0;
          if (cmd == CMD_RSVD) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            // Preload the divider at period end so the next edge raises scs with bit 0.
            state_d = HDR;
            sh_d    = hdr_sh;
            bcnt_d  = 5'(N);
            div_d   = DIVW'(CLKDIV - 1);
          end
        end
      end
      HDR, RDATA, WDATA: begin
        div_d = period_end ? '0 : div_q + 1'b1;
        if (div_q == DIVW'(HALF - 1)) sclk_d = 1'b1;
        if (period_end) begin
          sclk_d = 1'b0;
          if (state_q == RDATA) sh_d = {sh_q[SW-2:0], eep_sdo};
          if (bcnt_q != 5'd0) begin
            scs_d  = 1'b1;
            bcnt_d = bcnt_q - 1'b1;
            if (state_q != RDATA) begin
              sdi_d = sh_q[SW-1];
              sh_d  = sh_q << 1;
            end
          end else if (state_q == HDR && cmd_q == CMD_READ) begin
            state_d = RDATA;
            sdi_d   = 1'b0;
            bcnt_d  = 5'(DW - 1);
          end else if (state_q == HDR && (cmd_q == CMD_WRITE || cmd_q == CMD_WRAL)) begin
            state_d = WDATA;
            sdi_d   = wd_q[DW-1];
            sh_d    = wd_sh << 1;
            bcnt_d  = 5'(DW - 1);
          end else begin
            sdi_d   = 1'b0;
            state_d = (state_q == RDATA) ? FIN : CSLOW;
          end
        end
      end
      CSLOW: begin
        div_d = div_q + 1'b1;
        if (div_q == DIVW'(HALF - 1)) begin
          scs_d = 1'b0;
          if (!write_type) state_d = FIN;
        end
        if (div_q == DIVW'(HALF - 1 + CLKDIV)) begin
`ifdef JT9346_MASTER_POLL_EN
          state_d = POLL;
          scs_d   = 1'b1;
          pcnt_d  = '0;
`else
          state_d = FIN;
`endif
        end
      end
      POLL: begin
        pcnt_d = pcnt_q + 1'b1;
        if (eep_sdo) begin
          scs_d   = 1'b0;
          state_d = FIN;
        end else if (pcnt_q == PW'(TIMEOUT - 2)) begin
          scs_d   = 1'b0;
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        // Coming from RDATA, chip select still has half a period to run.
        div_d = div_q + 1'b1;
        if (scs_q) begin
          if (div_q == DIVW'(HALF - 1)) scs_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (cmd_q == CMD_READ) rdata_d = sh_q[DW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  cmd_q  <= '0;   wd_q   <= '0;   sh_q    <= '0;
      bcnt_q  <= '0;    div_q  <= '0;   pcnt_q <= '0;   busy_q  <= 1'b0;
      done_q  <= 1'b0;  err_q  <= 1'b0; scs_q  <= 1'b0; sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;  rdata_q <= '1;
    end else begin
      state_q <= state_d; cmd_q  <= cmd_d;  wd_q   <= wd_d;   sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;  div_q  <= div_d;  pcnt_q <= pcnt_d; busy_q  <= busy_d;
      done_q  <= done_d;  err_q  <= err_d;  scs_q  <= scs_d;  sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;   rdata_q <= rdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign eep_scs  = scs_q;
  assign eep_sclk = sclk_q;
  assign eep_sdi  = sdi_q;
endmodule
